thermo_vote_sequencer: RTL

Sequential front-end for the thermometer-code majority voter. It collects four thermometer-coded samples from a single valid/ready stream and buffers them. It then computes the per-bit threshold vote across the four samples and presents the result on a valid/ready output, holding it until accepted. It sits between the sample producer (e.g. comparator/flash-ADC capture) and downstream decode logic.

---
 rtl/thermo_vote_sequencer_if.sv | 41 ++++
 rtl/thermo_vote_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/thermo_vote_sequencer_if.sv
// ---------------------------------------------------------------------------
// thermo_vote_sequencer_if
// Groups the sample input stream and the vote result stream of the
// thermometer vote sequencer into one bundle.
//
// Signals:
//   in_valid  producer -> sequencer   sample valid
//   in_ready  sequencer -> producer   sample can be accepted this cycle
//   in_data   producer -> sequencer   W-bit thermometer-coded sample
//   out_valid sequencer -> consumer   vote result valid
//   out_ready consumer -> sequencer   consumer accepts result
//   out_data  sequencer -> consumer   W-bit voted thermometer code
//   out_err   sequencer -> consumer   batch contained an illegal sample
//
// Modports:
//   master  the environment side (producer + consumer)
//   slave   the sequencer side
// ---------------------------------------------------------------------------
interface thermo_vote_sequencer_if #(
  parameter int W = 15
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err
  );

endinterface

// File: rtl/thermo_vote_sequencer.sv
// ---------------------------------------------------------------------------
// thermo_vote_sequencer
// Collects four thermometer-coded samples from a valid/ready stream, then
// produces the per-bit threshold vote (bit i is 1 when at least THRESH of
// the four samples have bit i set) and holds it on a valid/ready output
// until the consumer takes it.
//
// Parameters:
//   W       sample width in bits
//   THRESH  minimum number of set bits out of 4 for an output bit to be 1
//   CNT_W   width of the delivered-vote counter
//
// Ports:
//   clk       clock, all state on the rising edge
//   rst_n     asynchronous active-low reset
//   flush     synchronous abort of the current batch / pending result
//   bus       slave side of thermo_vote_sequencer_if (both streams)
//   vote_cnt  results accepted downstream since reset, wraps
//
// Build option:
//   THERMO_CHECK_EN  when defined, every accepted sample is checked for
//                    legal thermometer form (0..01..1) and out_err reports
//                    a sticky per-batch error; when undefined out_err is 0.
// ---------------------------------------------------------------------------
module thermo_vote_sequencer #(
  parameter int W      = 15,
  parameter int THRESH = 3,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  thermo_vote_sequencer_if.slave bus,
  output logic [CNT_W-1:0]      vote_cnt
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VOTE    = 2'd1,
    HOLD    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       slotCnt_q, slotCnt_d;
  logic [W-1:0]     slot_q [4];
  logic [W-1:0]     slot_d [4];
  logic [W-1:0]     outData_q, outData_d;
  logic [CNT_W-1:0] voteCnt_q, voteCnt_d;
  logic [W-1:0]     voteBits;
  logic             inReady;
  logic             accept;

  // Ready is gated with rst_n so the producer never sees a ready while the
  // block is held in reset, even though the reset state is COLLECT.
  assign inReady       = rst_n && (state_q == COLLECT);
  assign accept        = bus.in_valid && inReady;
  assign bus.in_ready  = inReady;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = outData_q;
  assign vote_cnt      = voteCnt_q;

  // Per-bit tally of the four buffered samples compared against THRESH.
  always_comb begin
    voteBits = '0;
    for (int i = 0; i < W; i++) begin
      logic [2:0] tally;
      tally = {2'b00, slot_q[0][i]} + {2'b00, slot_q[1][i]}
            + {2'b00, slot_q[2][i]} + {2'b00, slot_q[3][i]};
      voteBits[i] = (tally >= 3'(THRESH));
    end
  end

  // Next-state logic. Flush overrides everything: it drops any sample
  // transfer and any result handshake in the same cycle, but leaves the
  // last result and the delivered counter alone.
  always_comb begin
    state_d   = state_q;
    slotCnt_d = slotCnt_q;
    slot_d    = slot_q;
    outData_d = outData_q;
    voteCnt_d = voteCnt_q;
    if (flush) begin
      state_d   = COLLECT;
      slotCnt_d = 2'd0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            slot_d[slotCnt_q] = bus.in_data;
            slotCnt_d         = slotCnt_q + 2'd1;
            if (slotCnt_q == 2'd3) begin
              slotCnt_d = 2'd0;
              state_d   = VOTE;
            end
          end
        end
        VOTE: begin
          outData_d = voteBits;
          state_d   = HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            voteCnt_d = voteCnt_q + CNT_W'(1);
            state_d   = COLLECT;
          end
        end
        default: begin
          state_d   = COLLECT;
          slotCnt_d = 2'd0;
        end
      endcase
    end
  end

  // State registers; reset returns everything to an empty, idle block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      slotCnt_q <= 2'd0;
      for (int k = 0; k < 4; k++) slot_q[k] <= '0;
      outData_q <= '0;
      voteCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      slotCnt_q <= slotCnt_d;
      for (int k = 0; k < 4; k++) slot_q[k] <= slot_d[k];
      outData_q <= outData_d;
      voteCnt_q <= voteCnt_d;
    end
  end

`ifdef THERMO_CHECK_EN
  logic         errSticky_q, errSticky_d;
  logic         outErr_q, outErr_d;
  logic [W-1:0] dataPlusOne;
  logic         sampleIllegal;

  // A legal thermometer code x has no bit shared with x+1 (all-ones wraps
  // to zero, so it is legal too).
  assign dataPlusOne   = bus.in_data + W'(1);
  assign sampleIllegal = |(bus.in_data & dataPlusOne);
  assign bus.out_err   = outErr_q;

  // Sticky error restarts with the first sample of a batch and is latched
  // into the result alongside the vote.
  always_comb begin
    errSticky_d = errSticky_q;
    outErr_d    = outErr_q;
    if (flush) begin
      errSticky_d = 1'b0;
    end else if (state_q == COLLECT && accept) begin
      errSticky_d = ((slotCnt_q == 2'd0) ? 1'b0 : errSticky_q) | sampleIllegal;
    end else if (state_q == VOTE) begin
      outErr_d = errSticky_q;
    end
  end

  // Error registers share the reset behaviour of the main datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errSticky_q <= 1'b0;
      outErr_q    <= 1'b0;
    end else begin
      errSticky_q <= errSticky_d;
      outErr_q    <= outErr_d;
    end
  end
`else
  assign bus.out_err = 1'b0;
`endif

endmodule
